// File: rtl/rc4_phase_sequencer.sv
// rtl/rc4_phase_sequencer.sv - sequences init/shuffle/decrypt passes over a shared S-memory port.
// Optional cycle counter output enabled by RC4_SEQ_CYCLE_COUNT_EN.
`timescale 1ns/1ps
module rc4_phase_sequencer #(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_LENGTH     = 8,
  parameter int KEY_LENGTH     = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            go,
  input  logic [KEY_LENGTH*RAM_WIDTH-1:0] key_in,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0] key_out,
  output logic                            init_start,
  output logic                            shuf_start,
  output logic                            dec_start,
  input  logic                            init_finished,
  input  logic                            shuf_finished,
  input  logic                            dec_finished,
  input  logic [RAM_LENGTH-1:0]           init_addr,
  input  logic [RAM_LENGTH-1:0]           shuf_addr,
  input  logic [RAM_LENGTH-1:0]           dec_addr,
  input  logic [RAM_WIDTH-1:0]            init_data,
  input  logic [RAM_WIDTH-1:0]            shuf_data,
  input  logic [RAM_WIDTH-1:0]            dec_data,
  input  logic                            init_wren,
  input  logic                            shuf_wren,
  input  logic                            dec_wren,
  output logic [RAM_LENGTH-1:0]           ram_address,
  output logic [RAM_WIDTH-1:0]            ram_data,
  output logic                            ram_wren,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [2:0]                      phase
`ifdef RC4_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]                     cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SHUF  = 3'd2,
    S_DEC   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [KEY_LENGTH*RAM_WIDTH-1:0] key_q, key_d;
  logic                            init_start_q, init_start_d;
  logic                            shuf_start_q, shuf_start_d;
  logic                            dec_start_q, dec_start_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            error_q, error_d;
  logic [2:0]                      phase_q, phase_d;
  logic                            run, first, fin, timeout, go_acc;
`ifdef RC4_SEQ_CYCLE_COUNT_EN
  logic [31:0]                     cc_q, cc_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    init_start_d = 1'b0;
    shuf_start_d = 1'b0;
    dec_start_d  = 1'b0;
    go_acc       = 1'b0;
    run          = (state_q == S_INIT) || (state_q == S_SHUF) || (state_q == S_DEC);
    // The start pulse marks the first cycle of a phase; a finished level seen then is stale.
    first        = init_start_q | shuf_start_q | dec_start_q;
    timeout      = (cnt_q == CW'(TIMEOUT_CYCLES - 2));
    case (state_q)
      S_INIT:  fin = init_finished;
      S_SHUF:  fin = shuf_finished;
      S_DEC:   fin = dec_finished;
      default: fin = 1'b0;
    endcase
    if (run) cnt_d = cnt_q + CW'(1);
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          go_acc       = 1'b1;
          key_d        = key_in;
          state_d      = S_INIT;
          cnt_d        = '0;
          init_start_d = 1'b1;
        end
      end
      S_INIT: begin
        if (fin && !first) begin
          state_d      = S_SHUF;
          cnt_d        = '0;
          shuf_start_d = 1'b1;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_SHUF: begin
        if (fin && !first) begin
          state_d     = S_DEC;
          cnt_d       = '0;
          dec_start_d = 1'b1;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_DEC: begin
        if (fin && !first) state_d = S_DONE;
        else if (timeout)  state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
    phase_d = state_d;
    busy_d  = (state_d == S_INIT) || (state_d == S_SHUF) || (state_d == S_DEC);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

`ifdef RC4_SEQ_CYCLE_COUNT_EN
  always_comb begin
    cc_d = cc_q;
    if (go_acc)                      cc_d = '0;
    else if (run && (cc_q != '1))    cc_d = cc_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      dec_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      phase_q      <= 3'd0;
`ifdef RC4_SEQ_CYCLE_COUNT_EN
      cc_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      init_start_q <= init_start_d;
      shuf_start_q <= shuf_start_d;
      dec_start_q  <= dec_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      phase_q      <= phase_d;
`ifdef RC4_SEQ_CYCLE_COUNT_EN
      cc_q         <= cc_d;
`endif
    end
  end

  // Unregistered mux so each pass keeps its own RAM timing.
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    case (state_q)
      S_INIT: begin ram_address = init_addr; ram_data = init_data; ram_wren = init_wren; end
      S_SHUF: begin ram_address = shuf_addr; ram_data = shuf_data; ram_wren = shuf_wren; end
      S_DEC:  begin ram_address = dec_addr;  ram_data = dec_data;  ram_wren = dec_wren;  end
      default: ;
    endcase
  end

  assign key_out    = key_q;
  assign init_start = init_start_q;
  assign shuf_start = shuf_start_q;
  assign dec_start  = dec_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign phase      = phase_q;
`ifdef RC4_SEQ_CYCLE_COUNT_EN
  assign cycle_count = cc_q;
`endif

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// tb/tb_rc4_phase_sequencer.sv - bench for rc4_phase_sequencer (RC4_SEQ_CYCLE_COUNT_EN optional).
`timescale 1ns/1ps
module tb_rc4_phase_sequencer;
  logic        clk = 1'b0;
  logic        reset, go;
  logic [23:0] key_in;
  logic        init_finished, shuf_finished, dec_finished;
  logic [7:0]  init_addr, shuf_addr, dec_addr, init_data, shuf_data, dec_data;
  logic        init_wren, shuf_wren, dec_wren;

  logic [23:0] key_out, key_out_b;
  logic        init_start, shuf_start, dec_start, init_start_b, shuf_start_b, dec_start_b;
  logic [7:0]  ram_address, ram_data, ram_address_b, ram_data_b;
  logic        ram_wren, busy, done, error, ram_wren_b, busy_b, done_b, error_b;
  logic [2:0]  phase, phase_b;
`ifdef RC4_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count, cycle_count_b;
`endif

  rc4_phase_sequencer #(.RAM_WIDTH(8), .RAM_LENGTH(8), .KEY_LENGTH(3), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .reset(reset), .go(go), .key_in(key_in), .key_out(key_out),
    .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
    .init_finished(init_finished), .shuf_finished(shuf_finished), .dec_finished(dec_finished),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .done(done), .error(error), .phase(phase)
`ifdef RC4_SEQ_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  rc4_phase_sequencer #(.RAM_WIDTH(8), .RAM_LENGTH(8), .KEY_LENGTH(3), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .go(go), .key_in(key_in), .key_out(key_out_b),
    .init_start(init_start_b), .shuf_start(shuf_start_b), .dec_start(dec_start_b),
    .init_finished(init_finished), .shuf_finished(shuf_finished), .dec_finished(dec_finished),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
    .ram_address(ram_address_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b),
    .busy(busy_b), .done(done_b), .error(error_b), .phase(phase_b)
`ifdef RC4_SEQ_CYCLE_COUNT_EN
    , .cycle_count(cycle_count_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int which; int rel; } ev_t;
  typedef struct {
    logic [7:0] ia, id; logic iw;
    logic [7:0] sa, sd; logic sw;
    logic [7:0] da, dd; logic dw;
    logic [7:0] ea, ed; logic ew;
  } mv_t;

  ev_t exp_q[$];
  mv_t tbl[4];
  int  n_vec = 0, n_bad = 0;
  int  cyc = 0, base = 0;
  int  il, sl, dl, ir, sr, dr;
  bit  shuf_force, msel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (rel cycle %0d)", nm, act, exp, cyc - base);
    end
  endtask

  task automatic model();
    logic is, ss, ds;
    is = msel ? init_start_b : init_start;
    ss = msel ? shuf_start_b : shuf_start;
    ds = msel ? dec_start_b  : dec_start;
    if (is) ir = 0; else if (ir >= 0) ir++;
    if (ss) sr = 0; else if (sr >= 0) sr++;
    if (ds) dr = 0; else if (dr >= 0) dr++;
    init_finished = (ir >= 0) && (ir == il);
    shuf_finished = ((sr >= 0) && (sr == sl)) || shuf_force;
    dec_finished  = (dr >= 0) && (dr == dl);
    if (init_finished) ir = -1;
    if ((sr >= 0) && (sr == sl)) sr = -1;
    if (dec_finished) dr = -1;
  endtask

  task automatic scoreboard();
    logic [2:0] st;
    ev_t e;
    st = msel ? {dec_start_b, shuf_start_b, init_start_b} : {dec_start, shuf_start, init_start};
    for (int w = 0; w < 3; w++) begin
      if (st[w]) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_start: got pass %0d at rel cycle %0d expected none", w, cyc - base);
        end else begin
          e = exp_q.pop_front();
          chk("start_which", 32'(w), 32'(e.which));
          chk("start_cycle", 32'(cyc - base), 32'(e.rel));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model();
    scoreboard();
  endtask

  task automatic push_ev(input int w, input int r);
    ev_t e;
    e.which = w; e.rel = r;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0;
    step(); step();
    reset = 1'b0;
    ir = -1; sr = -1; dr = -1;
  endtask

  task automatic send_go(input logic [23:0] k);
    key_in = k; go = 1'b1; base = cyc;
    step();
    go = 1'b0;
  endtask

  task automatic apply_mv(input mv_t v);
    init_addr = v.ia; init_data = v.id; init_wren = v.iw;
    shuf_addr = v.sa; shuf_data = v.sd; shuf_wren = v.sw;
    dec_addr  = v.da; dec_data  = v.dd; dec_wren  = v.dw;
  endtask

  task automatic wait_rel(input int r);
    int n = 0;
    while ((cyc - base) < r && n < 5000) begin step(); n++; end
  endtask

  initial begin
    tbl[0] = '{8'h11, 8'h22, 1'b1, 8'h5A, 8'hC3, 1'b1, 8'h33, 8'h44, 1'b1, 8'h5A, 8'hC3, 1'b1};
    tbl[1] = '{8'h00, 8'h00, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hA5, 8'h3C, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 8'h77, 8'h88, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{8'h01, 8'h02, 1'b0, 8'hFF, 8'h80, 1'b1, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h80, 1'b1};
    key_in = '0; shuf_force = 1'b0; msel = 1'b0;
    init_finished = 0; shuf_finished = 0; dec_finished = 0;
    apply_mv(tbl[0]);
    il = -1; sl = -1; dl = -1;
    do_reset();

    // Reset state
    chk("rst_phase", 32'(phase), 0);
    chk("rst_busy_done_error", 32'({busy, done, error}), 0);
    chk("rst_starts", 32'({init_start, shuf_start, dec_start}), 0);
    chk("rst_key_out", 32'(key_out), 0);
    chk("rst_ram", 32'({ram_address, ram_data, ram_wren}), 0);

    // Full run: passes finish 256/1024/300 cycles after their start pulses
    il = 256; sl = 1024; dl = 300;
    push_ev(0, 1); push_ev(1, 258); push_ev(2, 1283);
    send_go(24'h000249);
    chk("run_phase1", 32'(phase), 1);
    chk("run_busy", 32'(busy), 1);
    begin
      int n = 0;
      while (!done && n < 3000) begin step(); n++; end
    end
    chk("done_cycle", 32'(cyc - base), 1584);
    chk("done_phase", 32'(phase), 4);
    chk("done_busy", 32'(busy), 0);
    chk("done_key_out", 32'(key_out), 32'h249);
`ifdef RC4_SEQ_CYCLE_COUNT_EN
    chk("cycle_count_done", cycle_count, 1583);
`endif
    step();
    chk("done_hold", 32'(done), 1);

    // Stale shuf_finished held from INIT into the SHUF start cycle
    il = 3; sl = -1; dl = 2; shuf_force = 1'b1;
    push_ev(0, 1); push_ev(1, 5); push_ev(2, 7);
    send_go(24'hABCDEF);
`ifdef RC4_SEQ_CYCLE_COUNT_EN
    chk("cycle_count_cleared", cycle_count, 0);
`endif
    wait_rel(5);
    chk("stale_shuf_c5", 32'(phase), 2);
    step();
    chk("stale_shuf_c6", 32'(phase), 2);
    step();
    chk("stale_dec_c7", 32'(phase), 3);
    shuf_force = 1'b0;
    begin
      int n = 0;
      while (!done && n < 50) begin step(); n++; end
    end
    chk("stale_done_cycle", 32'(cyc - base), 10);
    chk("stale_key_out", 32'(key_out), 32'hABCDEF);

    // RAM mux: zeros in IDLE, shuf_* selected in SHUF
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_mv(tbl[i]); #1;
      chk("mux_idle", 32'({ram_address, ram_data, ram_wren}), 0);
    end
    il = 2; sl = -1; dl = -1;
    push_ev(0, 1); push_ev(1, 4);
    send_go(24'h123456);
    wait_rel(4);
    for (int i = 0; i < 4; i++) begin
      apply_mv(tbl[i]); #1;
      chk("mux_shuf_addr", 32'(ram_address), 32'(tbl[i].ea));
      chk("mux_shuf_data", 32'(ram_data), 32'(tbl[i].ed));
      chk("mux_shuf_wren", 32'(ram_wren), 32'(tbl[i].ew));
    end
    apply_mv(tbl[0]);

    // go held during SHUF is ignored; reset at SHUF cycle 10 clears everything
    go = 1'b1;
    wait_rel(13);
    chk("go_ignored_phase", 32'(phase), 2);
    chk("go_ignored_start", 32'(init_start), 0);
    reset = 1'b1;
    step();
    chk("midrst_phase", 32'(phase), 0);
    chk("midrst_flags", 32'({busy, done, error}), 0);
    chk("midrst_starts", 32'({init_start, shuf_start, dec_start}), 0);
    chk("midrst_ram", 32'({ram_address, ram_data, ram_wren}), 0);
    chk("midrst_key", 32'(key_out), 0);
    go = 1'b0;
    step();
    reset = 1'b0;
    ir = -1; sr = -1; dr = -1;

    // Watchdog on the TIMEOUT_CYCLES=16 instance: dec_finished never arrives
    msel = 1'b1;
    do_reset();
    il = 5; sl = 5; dl = -1;
    push_ev(0, 1); push_ev(1, 7); push_ev(2, 13);
    send_go(24'h0F0F0F);
    wait_rel(27);
    chk("to_last_dec", 32'(phase_b), 3);
    step();
    chk("to_phase", 32'(phase_b), 5);
    chk("to_error", 32'(error_b), 1);
    chk("to_busy", 32'(busy_b), 0);
    chk("to_ram_wren", 32'(ram_wren_b), 0);
    step();
    chk("to_hold", 32'(error_b), 1);
    push_ev(0, 1);
    send_go(24'h0F0F0F);
    chk("to_restart_phase", 32'(phase_b), 1);
    chk("to_restart_error", 32'(error_b), 0);

    chk("events_left", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
